// File: rtl/mvp_bitserial_ctrl.sv
// Bit-serial MVP sequencer: walks tiles x weight bit-planes x input bit-planes, issues
// memory reads and emits LAT-delayed mvp mode and shift-accumulator strobes.
module mvp_bitserial_ctrl #(
  parameter int BPREC = 4,
  parameter int BLEN  = 8,
  parameter int BADDR = 10,
  parameter int LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BPREC-1:0]     wprec,
  input  logic [BPREC-1:0]     iprec,
  input  logic                 wsigned,
  input  logic                 isigned,
  input  logic [BLEN-1:0]      ilen,
  input  logic [BADDR-1:0]     wbase,
  input  logic [BADDR-1:0]     ibase,
  input  logic                 stall,
  output logic [BADDR-1:0]     w_addr,
  output logic [BADDR-1:0]     i_addr,
  output logic                 rd_en,
  output logic [1:0]           mode,
  output logic                 acc_en,
  output logic                 acc_clr,
  output logic [2*BPREC-1:0]   acc_shamt,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = 2 * BPREC;
  localparam int T  = LAT - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [BPREC-1:0] wprec_q, iprec_q;
  logic             wsigned_q, isigned_q;
  logic [BLEN-1:0]  ilen_q;
  logic [BLEN-1:0]  tile;
  logic [BPREC-1:0] wbit, ibit;
  logic [BADDR-1:0] wtile_base, itile_base;
  logic [BADDR-1:0] wstep, istep;

  logic             accept, zero_job, issue;
  logic             wbit_top, ibit_top;
  logic             first_issue, last_issue, neg;
  logic [SW-1:0]    shamt;
  logic             upstream_empty;

  logic [LAT-1:0]   pipe_vld;
  logic [LAT-1:0]   pipe_neg;
  logic [LAT-1:0]   pipe_first;
  logic [LAT-1:0]   pipe_last;
  logic [SW-1:0]    pipe_shamt [LAT];

  assign accept   = (state == IDLE) && start;
  assign zero_job = (wprec == '0) || (iprec == '0) || (ilen == '0);

  assign wstep    = BADDR'(wprec_q);
  assign istep    = BADDR'(iprec_q);

  assign wbit_top    = (wbit == wprec_q - BPREC'(1));
  assign ibit_top    = (ibit == iprec_q - BPREC'(1));
  assign first_issue = (tile == '0) && wbit_top && ibit_top;
  assign last_issue  = (tile == ilen_q - BLEN'(1)) && (wbit == '0) && (ibit == '0);
  // The sign bit-plane of a two's complement operand carries negative weight.
  assign neg         = (wsigned_q && wbit_top) ^ (isigned_q && ibit_top);
  assign shamt       = SW'(wbit) + SW'(ibit);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = zero_job ? DONE : RUN;
      RUN:     if (issue && last_issue) state_nxt = DRAIN;
      DRAIN:   if (!stall && upstream_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    issue = (state == RUN) && !stall;
    rd_en = issue;
  end

  // ---------------------------------------------------------------- job fields and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wprec_q    <= '0;
      iprec_q    <= '0;
      wsigned_q  <= 1'b0;
      isigned_q  <= 1'b0;
      ilen_q     <= '0;
      tile       <= '0;
      wbit       <= '0;
      ibit       <= '0;
      wtile_base <= '0;
      itile_base <= '0;
      w_addr     <= '0;
      i_addr     <= '0;
    end else if (accept) begin
      wprec_q    <= wprec;
      iprec_q    <= iprec;
      wsigned_q  <= wsigned;
      isigned_q  <= isigned;
      ilen_q     <= ilen;
      tile       <= '0;
      wbit       <= wprec - BPREC'(1);
      ibit       <= iprec - BPREC'(1);
      wtile_base <= wbase;
      itile_base <= ibase;
      w_addr     <= wbase + BADDR'(wprec) - BADDR'(1);
      i_addr     <= ibase + BADDR'(iprec) - BADDR'(1);
    end else if (issue && !last_issue) begin
      // The address registers always point at the slot about to be issued.
      if (ibit != '0) begin
        ibit   <= ibit - BPREC'(1);
        i_addr <= i_addr - BADDR'(1);
      end else begin
        ibit <= iprec_q - BPREC'(1);
        if (wbit != '0) begin
          wbit   <= wbit - BPREC'(1);
          w_addr <= w_addr - BADDR'(1);
          i_addr <= itile_base + istep - BADDR'(1);
        end else begin
          wbit       <= wprec_q - BPREC'(1);
          tile       <= tile + BLEN'(1);
          wtile_base <= wtile_base + wstep;
          itile_base <= itile_base + istep;
          w_addr     <= wtile_base + wstep + wstep - BADDR'(1);
          i_addr     <= itile_base + istep + istep - BADDR'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- memory+mvp delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld   <= '0;
      pipe_neg   <= '0;
      pipe_first <= '0;
      pipe_last  <= '0;
      for (int s = 0; s < LAT; s++) pipe_shamt[s] <= '0;
    end else if (!stall) begin
      for (int s = LAT - 1; s > 0; s--) begin
        pipe_vld[s]   <= pipe_vld[s-1];
        pipe_neg[s]   <= pipe_neg[s-1];
        pipe_first[s] <= pipe_first[s-1];
        pipe_last[s]  <= pipe_last[s-1];
        pipe_shamt[s] <= pipe_shamt[s-1];
      end
      pipe_vld[0]   <= issue;
      pipe_neg[0]   <= issue && neg;
      pipe_first[0] <= issue && first_issue;
      pipe_last[0]  <= issue && last_issue;
      pipe_shamt[0] <= issue ? shamt : '0;
    end
  end

  // The output stage is consumed this cycle; only the stages behind it gate the drain.
  always_comb begin
    upstream_empty = 1'b1;
    for (int s = 0; s < LAT - 1; s++) begin
      if (pipe_vld[s]) upstream_empty = 1'b0;
    end
  end

  always_comb begin
    acc_en    = pipe_vld[T] && !stall;
    acc_clr   = acc_en && pipe_first[T];
    out_valid = acc_en && pipe_last[T];
    mode      = !pipe_vld[T] ? 2'b00 : (pipe_neg[T] ? 2'b10 : 2'b01);
    acc_shamt = pipe_vld[T] ? pipe_shamt[T] : '0;
  end

endmodule

// File: tb/tb_mvp_bitserial_ctrl.sv
// Bench for mvp_bitserial_ctrl: directed vector table, literal corner sequences, and
// randomized jobs checked against a loop-nest model of the issue/accumulate schedule.
`timescale 1ns/1ps
module tb_mvp_bitserial_ctrl;

  localparam int BPREC = 4;
  localparam int BLEN  = 8;
  localparam int BADDR = 10;
  localparam int LAT   = 2;
  localparam int MAXC  = 4096;

  logic                 clk = 1'b0;
  logic                 rst, start, wsigned, isigned, stall;
  logic [BPREC-1:0]     wprec, iprec;
  logic [BLEN-1:0]      ilen;
  logic [BADDR-1:0]     wbase, ibase;
  logic [BADDR-1:0]     w_addr, i_addr;
  logic                 rd_en, acc_en, acc_clr, out_valid, busy, done;
  logic [1:0]           mode;
  logic [2*BPREC-1:0]   acc_shamt;

  always #5 clk = ~clk;

  mvp_bitserial_ctrl #(.BPREC(BPREC), .BLEN(BLEN), .BADDR(BADDR), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .wprec(wprec), .iprec(iprec),
    .wsigned(wsigned), .isigned(isigned), .ilen(ilen), .wbase(wbase), .ibase(ibase),
    .stall(stall), .w_addr(w_addr), .i_addr(i_addr), .rd_en(rd_en), .mode(mode),
    .acc_en(acc_en), .acc_clr(acc_clr), .acc_shamt(acc_shamt), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  typedef struct {
    int wp, ip, ws, is, len, wb, ib, smode;
    int exp_n, exp_done;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int got_w[$], got_i[$], got_mode[$], got_sh[$], got_clr[$], got_ov[$];
  int iss_cyc[$], acc_cyc[$];
  int done_cyc, stray;
  bit stall_pat [MAXC];
  bit noisy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_stall(input int smode);
    for (int k = 0; k < MAXC; k++) begin
      stall_pat[k] = 1'b0;
      if (smode == 1) stall_pat[k] = ($urandom_range(0, 3) == 0);
      if (smode == 2 && k >= 3 && k <= 5) stall_pat[k] = 1'b1;
    end
  endtask

  // k-th cycle index after 'from' that is not stalled, for n = 1, 2, ...
  function automatic int nth_free(input int from, input int n);
    int k = from;
    int c = 0;
    while (c < n && k < MAXC - 1) begin
      k++;
      if (!stall_pat[k]) c++;
    end
    return k;
  endfunction

  task automatic run_job(input int wp, input int ip, input int ws, input int is,
                         input int len, input int wb, input int ib);
    got_w.delete(); got_i.delete(); got_mode.delete(); got_sh.delete();
    got_clr.delete(); got_ov.delete(); iss_cyc.delete(); acc_cyc.delete();
    done_cyc = -1;
    stray    = 0;
    @(negedge clk);
    wprec = BPREC'(wp); iprec = BPREC'(ip); wsigned = 1'(ws); isigned = 1'(is);
    ilen = BLEN'(len); wbase = BADDR'(wb); ibase = BADDR'(ib);
    start = 1'b1; stall = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < MAXC; k++) begin
      stall = stall_pat[k];
      if (noisy) begin
        start = 1'($urandom); wprec = BPREC'($urandom); iprec = BPREC'($urandom);
        ilen = BLEN'($urandom); wbase = BADDR'($urandom); ibase = BADDR'($urandom);
      end
      #1;
      if (rd_en) begin
        got_w.push_back(int'(w_addr)); got_i.push_back(int'(i_addr)); iss_cyc.push_back(k);
      end
      if (acc_en) begin
        got_mode.push_back(int'(mode)); got_sh.push_back(int'(acc_shamt));
        got_clr.push_back(int'(acc_clr)); got_ov.push_back(int'(out_valid));
        acc_cyc.push_back(k);
      end
      if ((acc_clr || out_valid) && !acc_en) stray++;
      if (!busy) stray++;
      if (done) begin
        done_cyc = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0; stall = 1'b0;
    chk("job_completes", int'(done_cyc >= 0), 1);
    if (done_cyc < 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("idle_after_done", int'({busy, done, rd_en, acc_en}), 0);
  endtask

  // Expected schedule from the nested tile / weight-bit / input-bit iteration.
  task automatic check_model(input int wp, input int ip, input int ws, input int is,
                             input int len, input int wb, input int ib);
    int n, j, c, a, last_a, neg;
    n = (wp == 0 || ip == 0 || len == 0) ? 0 : wp * ip * len;
    chk("issue_count", got_w.size(), n);
    chk("acc_count", acc_cyc.size(), n);
    chk("stray_strobes", stray, 0);
    j = 0; c = 0; last_a = 0;
    for (int t = 0; t < len; t++) begin
      for (int wbit = wp - 1; wbit >= 0; wbit--) begin
        for (int ibit = ip - 1; ibit >= 0; ibit--) begin
          neg = int'((ws != 0 && wbit == wp - 1) != (is != 0 && ibit == ip - 1));
          c = nth_free(c, 1);
          a = nth_free(c, LAT);
          if (j < got_w.size()) begin
            chk("w_addr", got_w[j], (wb + t * wp + wbit) % (1 << BADDR));
            chk("i_addr", got_i[j], (ib + t * ip + ibit) % (1 << BADDR));
            chk("issue_cycle", iss_cyc[j], c);
          end
          if (j < acc_cyc.size()) begin
            chk("mode", got_mode[j], neg ? 2 : 1);
            chk("acc_shamt", got_sh[j], wbit + ibit);
            chk("acc_clr", got_clr[j], int'(j == 0));
            chk("out_valid", got_ov[j], int'(j == n - 1));
            chk("acc_cycle", acc_cyc[j], a);
          end
          last_a = a;
          j++;
        end
      end
    end
    chk("done_cycle", done_cyc, (n == 0) ? 1 : last_a + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int ew[6], ei[6], esh[6], emode[4], ew3[3];
    int ovs;

    vecs[0] = '{3, 2, 0, 0, 1, 'h10, 'h40, 0, 6, 9};
    vecs[1] = '{2, 2, 1, 1, 1, 0, 0, 0, 4, 7};
    vecs[2] = '{1, 1, 0, 0, 3, 'h3FE, 0, 0, 3, 6};
    vecs[3] = '{3, 2, 0, 0, 1, 'h10, 'h40, 2, 6, 12};
    vecs[4] = '{3, 0, 0, 0, 1, 'h10, 'h40, 0, 0, 1};
    vecs[5] = '{0, 4, 1, 0, 5, 0, 0, 0, 0, 1};
    vecs[6] = '{2, 2, 0, 1, 0, 0, 0, 0, 0, 1};
    vecs[7] = '{4, 3, 1, 0, 2, 'h3F0, 'h3FC, 0, 24, 27};
    vecs[8] = '{15, 15, 1, 1, 1, 'h100, 'h200, 0, 225, 228};

    rst = 1'b1; start = 1'b0; stall = 1'b0; wsigned = 1'b0; isigned = 1'b0;
    wprec = '0; iprec = '0; ilen = '0; wbase = '0; ibase = '0;
    #2;
    chk("reset_strobes", int'({rd_en, mode, acc_en, acc_clr, out_valid, busy, done}), 0);
    chk("reset_addr", int'(w_addr) + int'(i_addr), 0);
    chk("reset_shamt", int'(acc_shamt), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      fill_stall(vecs[v].smode);
      run_job(vecs[v].wp, vecs[v].ip, vecs[v].ws, vecs[v].is, vecs[v].len, vecs[v].wb, vecs[v].ib);
      chk($sformatf("vec%0d_issues", v), got_w.size(), vecs[v].exp_n);
      chk($sformatf("vec%0d_done", v), done_cyc, vecs[v].exp_done);
      check_model(vecs[v].wp, vecs[v].ip, vecs[v].ws, vecs[v].is, vecs[v].len, vecs[v].wb, vecs[v].ib);
    end

    // Basic sequence, literal addresses and shifts.
    ew  = '{'h12, 'h12, 'h11, 'h11, 'h10, 'h10};
    ei  = '{'h41, 'h40, 'h41, 'h40, 'h41, 'h40};
    esh = '{3, 2, 2, 1, 1, 0};
    fill_stall(0);
    run_job(3, 2, 0, 0, 1, 'h10, 'h40);
    for (int j = 0; j < 6; j++) begin
      if (j < got_w.size()) begin
        chk("basic_w_addr", got_w[j], ew[j]);
        chk("basic_i_addr", got_i[j], ei[j]);
      end
      if (j < got_sh.size()) chk("basic_shamt", got_sh[j], esh[j]);
    end
    if (acc_cyc.size() == 6 && iss_cyc.size() == 6)
      chk("basic_ov_latency", acc_cyc[5] - iss_cyc[5], 2);
    chk("basic_done_after_ov", done_cyc, 9);

    // Stalled basic sequence keeps order and grows by the stall length.
    fill_stall(2);
    run_job(3, 2, 0, 0, 1, 'h10, 'h40);
    for (int j = 0; j < 6; j++) begin
      if (j < got_w.size()) begin
        chk("stall_w_addr", got_w[j], ew[j]);
        chk("stall_i_addr", got_i[j], ei[j]);
      end
    end
    if (iss_cyc.size() > 2) chk("stall_resume_cycle", iss_cyc[2], 6);
    chk("stall_job_len", done_cyc, 12);

    // Signed: sign planes subtract unless both operands are on their sign bit.
    emode = '{1, 2, 2, 1};
    fill_stall(0);
    run_job(2, 2, 1, 1, 1, 0, 0);
    for (int j = 0; j < 4; j++)
      if (j < got_mode.size()) chk("signed_mode", got_mode[j], emode[j]);

    // Multi-tile with address wrap.
    ew3 = '{'h3FE, 'h3FF, 'h000};
    run_job(1, 1, 0, 0, 3, 'h3FE, 0);
    for (int j = 0; j < 3; j++)
      if (j < got_w.size()) chk("wrap_w_addr", got_w[j], ew3[j]);
    ovs = 0;
    foreach (got_ov[j]) ovs += got_ov[j];
    chk("wrap_out_valid_count", ovs, 1);

    // Reset in the middle of RUN aborts the job.
    @(negedge clk);
    wprec = 3; iprec = 2; wsigned = 0; isigned = 0; ilen = 1; wbase = 'h10; ibase = 'h40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_strobes", int'({rd_en, mode, acc_en, acc_clr, out_valid, busy, done}), 0);
    chk("midrst_addr", int'(w_addr) + int'(i_addr), 0);
    chk("midrst_shamt", int'(acc_shamt), 0);
    @(negedge clk);
    rst = 1'b0;
    ovs = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      ovs += int'(out_valid) + int'(done) + int'(busy) + int'(acc_en);
    end
    chk("midrst_no_completion", ovs, 0);
    run_job(3, 2, 0, 0, 1, 'h10, 'h40);
    check_model(3, 2, 0, 0, 1, 'h10, 'h40);

    // Randomized jobs with random stalls and ignored start/field noise.
    for (int r = 0; r < 30; r++) begin
      int wp, ip, ws, is, len, wb, ib;
      wp  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      ip  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      len = int'($urandom_range(1, 4));
      ws  = int'($urandom_range(0, 1));
      is  = int'($urandom_range(0, 1));
      wb  = int'($urandom_range(0, 1023));
      ib  = int'($urandom_range(0, 1023));
      fill_stall(1);
      noisy = 1'b1;
      run_job(wp, ip, ws, is, len, wb, ib);
      noisy = 1'b0;
      check_model(wp, ip, ws, is, len, wb, ib);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvp_bitserial_ctrl.md
Name: mvp_bitserial_ctrl

Overview:
- Sequences the bit-serial MVP array for one multi-bit matrix-vector product.
- Iterates over vector tiles, weight bit-planes and input bit-planes, and generates the weight-memory and input-memory read addresses.
- Drives the MVP mode (add/subtract) and emits the accumulator control strobes, delay-matched to the memory+MVP pipeline.
- Sits between the job-dispatch logic and the memories/mvp/shift-accumulator.

Parameters:
- BPREC, 4: width of the precision fields. Precisions range 0..2^BPREC-1.
- BLEN, 8: width of the tile-count field.
- BADDR, 10: memory address width.
- LAT, 2: cycles from an address issue to the valid MVP output (1 for memory read + 1 for the MVP register).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  job request. Sampled only in IDLE.
- wprec  in  BPREC  weight precision in bits. Latched at start.
- iprec  in  BPREC  input precision in bits. Latched at start.
- wsigned  in  1  weights are two's complement. Latched at start.
- isigned  in  1  inputs are two's complement. Latched at start.
- ilen  in  BLEN  number of tiles. Latched at start.
- wbase  in  BADDR  weight base address. Latched at start.
- ibase  in  BADDR  input base address. Latched at start.
- stall  in  1  downstream hold. Freezes issue and pipeline.
- w_addr  out  BADDR  weight-memory read address.
- i_addr  out  BADDR  input-memory read address.
- rd_en  out  1  memory read strobe (issue).
- mode  out  2  to mvp, delayed LAT: 2'b01 add, 2'b10 subtract, 2'b00 idle.
- acc_en  out  1  accumulate the MVP result, delayed LAT.
- acc_clr  out  1  clear the accumulator before this add. Coincides with the first acc_en of the job.
- acc_shamt  out  2*BPREC  left shift applied to this partial = wb+ib, delayed LAT.
- out_valid  out  1  one-cycle pulse: accumulator holds the final result.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, pipeline valid bits cleared. Reset asserted mid-job aborts the job: no out_valid, no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start with wprec, iprec and ilen all nonzero.
  - IDLE -> DONE on start with any of them zero. No issue and no out_valid occur.
  - RUN -> DRAIN after the final issue.
  - DRAIN -> DONE once the LAT pipeline is empty.
  - DONE -> IDLE unconditionally after 1 cycle. done=1 in DONE.
- busy = state != IDLE. start outside IDLE is ignored.
- Issue order: tile t from 0 to ilen-1 (outer), weight bit wb from wprec-1 down to 0, input bit ib from iprec-1 down to 0 (inner).
  - One issue per non-stalled RUN cycle.
  - Total issues = ilen*wprec*iprec.
- Address generation, registered, valid with rd_en:
  - w_addr = wbase + t*wprec + wb.
  - i_addr = ibase + t*iprec + ib.
  - Arithmetic is modulo 2^BADDR; wrap-around is permitted and not flagged.
- Sign rule: neg = (wsigned && wb==wprec-1) XOR (isigned && ib==iprec-1). mode = neg ? 2'b10 : 2'b01 on valid slots, 2'b00 otherwise.
- Pipeline: a LAT-deep shift register carries {valid, neg, shamt, first, last}.
  - acc_en, mode, acc_shamt and acc_clr appear exactly LAT cycles after the corresponding rd_en, counting only non-stalled cycles.
  - out_valid = delayed last && acc_en, i.e. asserted the same cycle as the final acc_en.
- Stall:
  - While stall=1: no new issue, rd_en=0, the pipeline holds, and acc_en/out_valid are forced to 0.
  - Address outputs hold their values.
  - Stall in DRAIN freezes the drain.
  - Stall has no effect in IDLE or DONE.
- Latency from start to first rd_en: 1 cycle. Latency from final rd_en to out_valid: LAT cycles (no stall). done follows out_valid by 1 cycle.

Test Plan:
- Basic sequence: wprec=3, iprec=2, ilen=1, unsigned, wbase=0x10, ibase=0x40, LAT=2.
  - (w_addr,i_addr) = (12,41),(12,40),(11,41),(11,40),(10,41),(10,40) on 6 consecutive rd_en cycles.
  - acc_shamt = 3,2,2,1,1,0. acc_clr only with the first acc_en. out_valid 2 cycles after the last rd_en. done 1 cycle later.
- Signed: wsigned=isigned=1, wprec=iprec=2, ilen=1.
  - mode sequence 01,10,10,01, delayed 2 cycles from the rd_en pulses.
- Multi-tile: ilen=3, wprec=iprec=1, wbase=0x3FE.
  - Exactly 3 issues with w_addr = 3FE,3FF,000 (wrap), then one out_valid.
- Stall: stall=1 for 3 cycles after the 2nd issue of the basic-sequence job.
  - rd_en=0 and acc_en=0 during the stall. The issue order resumes unchanged.
  - Total issues=6. Total job length is 3 cycles longer than unstalled.
- Zero precision: start with iprec=0.
  - busy for 1 cycle, done pulse, no rd_en, acc_en or out_valid.
- Reset mid-operation: rst asserted during RUN.
  - All outputs 0 within the same cycle (async), FSM in IDLE.
  - A new start completes normally.
